// File: rtl/bin_frame_unpack.sv
// Reassembles a BW_OUT-bit serialized word stream (bin 0 first, MSB slice first)
// into one frame of BINS parallel SUM_WIDTH-bit bins, with SOF-based framing checks.
module bin_frame_unpack #(
    parameter int SUM_WIDTH = 32,
    parameter int BINS      = 4,
    parameter int BW_OUT    = 8
) (
    input  logic                                clk,
    input  logic                                arest,
    input  logic                                in_valid,
    input  logic                                in_sof,
    input  logic [BW_OUT-1:0]                   in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BINS-1:0][SUM_WIDTH-1:0]      out_data,
    output logic                                frame_err,
    output logic [15:0]                         err_count
);

    localparam int SLICES = SUM_WIDTH / BW_OUT;
    localparam int W      = BINS * SLICES;
    localparam int CW     = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    state_t                        state;
    logic [CW-1:0]                 cnt;
    logic [BINS*SUM_WIDTH-1:0]     frame_q;
    logic                          accept;
    logic                          wr_en;
    logic [CW-1:0]                 wr_idx;

    // Bit position of word k: bin k/SLICES, slice 0 holds that bin's MSBs.
    function automatic int word_offset(input int k);
        return (k / SLICES) * SUM_WIDTH + (SLICES - 1 - (k % SLICES)) * BW_OUT;
    endfunction

    assign accept = in_valid && in_ready && (state != HOLD);
    assign wr_en  = accept && (in_sof || (state == FILL));
    assign wr_idx = in_sof ? '0 : cnt;

    always_ff @(posedge clk or posedge arest) begin
        if (arest) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_sof) begin
                            cnt   <= CW'(1);
                            state <= FILL;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (in_sof) begin
                            // A fresh SOF restarts the frame; the partial one is lost.
                            frame_err <= 1'b1;
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            cnt <= CW'(1);
                        end else if (cnt == CW'(W - 1)) begin
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Frame storage only moves on accepted words, so a held frame is never disturbed.
    always_ff @(posedge clk or posedge arest) begin
        if (arest) begin
            frame_q <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < W; k++) begin
                if (wr_idx == CW'(k))
                    frame_q[word_offset(k) +: BW_OUT] <= in_data;
            end
        end
    end

    assign out_data = frame_q;

endmodule

// File: tb/tb_bin_frame_unpack.sv
// Scoreboard bench for bin_frame_unpack: expected frames are queued as bytes are
// driven and popped when the DUT completes a valid/ready handshake.
module tb_bin_frame_unpack;

    localparam int SUM_WIDTH = 32;
    localparam int BINS      = 4;
    localparam int BW_OUT    = 8;
    localparam int W         = 16;

    typedef logic [BINS-1:0][SUM_WIDTH-1:0] frame_t;

    logic        clk;
    logic        arest;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    frame_t      out_data;
    logic        frame_err;
    logic [15:0] err_count;

    int     errors;
    int     checks;
    int     err_pulses;
    frame_t exp_q[$];

    bin_frame_unpack #(
        .SUM_WIDTH(SUM_WIDTH),
        .BINS     (BINS),
        .BW_OUT   (BW_OUT)
    ) dut (
        .clk      (clk),
        .arest    (arest),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counted mid-cycle so every high cycle of frame_err is one pulse.
    always @(negedge clk) if (frame_err) err_pulses++;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t make_frame(input logic [7:0] first);
        frame_t     f;
        logic [7:0] b;
        f = '0;
        for (int k = 0; k < W; k++) begin
            b = first + 8'(k);
            f[k / 4][31 - 8 * (k % 4) -: 8] = b;
        end
        return f;
    endfunction

    task automatic drive_word(input logic [7:0] d, input logic sof, input int gap);
        int n;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] first, input bit random_gaps);
        exp_q.push_back(make_frame(first));
        for (int k = 0; k < W; k++) begin
            if (k == W - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL early_valid: out_valid=%b, want 0", out_valid);
                end
            end
            drive_word(first + 8'(k), k == 0, random_gaps ? int'($urandom_range(0, 1)) : 0);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency: out_valid=%b one clk after last word, want 1", out_valid);
        end
    endtask

    task automatic collect_frame(input int hold);
        int     n;
        frame_t exp;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL out_valid_timeout: out_valid=%b, want 1", out_valid);
            return;
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: queue size=0, want >0");
            return;
        end
        exp = exp_q.pop_front();
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp}) begin
                errors++;
                $display("[TB] FAIL hold_stable: valid=%b ready=%b data=%h, want 1 0 %h",
                         out_valid, in_ready, out_data, exp);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("[TB] FAIL frame_data: out_data=%h, want %h", out_data, exp);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL after_handshake: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic do_reset();
        arest = 1'b1;
        repeat (2) tick();
        checks++;
        if ({in_ready, out_valid, frame_err, err_count, out_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b valid=%b err=%b cnt=%h data=%h, want all 0",
                     in_ready, out_valid, frame_err, err_count, out_data);
        end
        arest = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        int p0;
        p0 = err_pulses;
        send_frame(8'h00, 1'b0);
        collect_frame(0);
        tick();
        checks++;
        if (err_pulses != p0) begin
            errors++;
            $display("[TB] FAIL basic_no_err: frame_err pulses=%0d, want 0", err_pulses - p0);
        end
    endtask

    task automatic test_backpressure();
        send_frame(8'h00, 1'b0);
        collect_frame(10);
    endtask

    task automatic test_stray_words();
        int p0;
        do_reset();
        p0 = err_pulses;
        for (int i = 0; i < 5; i++) drive_word(8'hE0 + 8'(i), 1'b0, 0);
        tick();
        checks++;
        if (err_pulses - p0 != 5 || err_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL stray_err: pulses=%0d err_count=%0d, want 5 5", err_pulses - p0, err_count);
        end
        send_frame(8'hA0, 1'b0);
        collect_frame(0);
    endtask

    task automatic test_sof_abort();
        int p0;
        do_reset();
        p0 = err_pulses;
        for (int k = 0; k < 7; k++) drive_word(8'h30 + 8'(k), k == 0, 0);
        send_frame(8'h50, 1'b0);
        collect_frame(0);
        checks++;
        if (err_pulses - p0 != 1 || err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL sof_abort_err: pulses=%0d err_count=%0d, want 1 1", err_pulses - p0, err_count);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h10, 1'b1);
        collect_frame(0);
        send_frame(8'h20, 1'b1);
        collect_frame(0);
        send_frame(8'hC0, 1'b1);
        collect_frame(0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 10; k++) drive_word(8'h70 + 8'(k), k == 0, 0);
        #3;
        arest = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, err_count, out_data} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%b ready=%b cnt=%h data=%h, want all 0",
                     out_valid, in_ready, err_count, out_data);
        end
        tick();
        arest = 1'b0;
        tick();
        send_frame(8'h90, 1'b0);
        collect_frame(0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        err_pulses = 0;
        arest      = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        #2;
        do_reset();
        test_basic_frame();
        test_backpressure();
        test_stray_words();
        test_sof_abort();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover: queue size=%0d, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
